// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: the segment font and
// the blank pattern. Segments are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int DEFAULT_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low segment pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_FONT[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with per-slot blanking and a
// per-frame shadow of the displayed value; all outputs registered (1 cycle).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int DIV    = 17,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     en_mask,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV-1:0] BLANK_C = DIV'(BLANK);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [DIV-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_tick_q, frame_tick_d;

  logic                cnt_max;
  logic                blank;
  logic [3:0]          nib;
  logic [6:0]          font_seg;

  assign cnt_max = &cnt_q;
  assign nib     = shadow_q[4*idx_q +: 4];

  hex_to_seg7 u_font (
    .nib_i   (nib),
    .seg_n_o (font_seg)
  );

  always_comb begin
    cnt_d       = cnt_q + DIV'(1);
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (cnt_max) begin
      if (idx_q == IDX_LAST) begin
        // Explicit wrap keeps non-power-of-2 digit counts in range; the frame
        // boundary is also where the displayed value is captured.
        idx_d       = '0;
        shadow_d    = value;
        shadow_dp_d = dp_mask;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    blank        = (cnt_q < BLANK_C) | ~en_mask[idx_q];
    an_n_d       = blank ? '1 : ~(DIGITS'(1) << idx_q);
    seg_n_d      = blank ? SEG_BLANK : font_seg;
    dp_n_d       = blank ? 1'b1 : ~shadow_dp_q[idx_q];
    frame_tick_d = (cnt_q == '0) & (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      an_n_q       <= '1;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with 16-cycle slots, 2 blank cycles, 8 digits; a
// cycle-position reference model predicts every output after reset release.
module tb_seg7_scan;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = 16;
  localparam int FRAME  = SLOT * DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  en_mask = '0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference state: edges since reset release and the value the display should
  // currently be showing (captured at each frame boundary).
  int          p = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_dp = '0;
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .en_mask    (en_mask),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h (p=%0d)", tag, obs, exp, p);
    end
  endtask

  task automatic step();
    int         slot;
    int         off;
    logic       blank;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    @(posedge clk);
    slot  = (p / SLOT) % DIGITS;
    off   = p % SLOT;
    blank = (off < BLANK) || !en_mask[slot];
    e_an  = blank ? 8'hFF : ~(8'h01 << slot);
    e_seg = blank ? 7'h7F : font[m_val[4*slot +: 4]];
    e_dp  = blank ? 1'b1 : ~m_dp[slot];
    e_ft  = (p % FRAME == 0);
    if (p % FRAME == FRAME - 1) begin
      m_val = value;
      m_dp  = dp_mask;
    end
    p++;
    #1;
    chk("an_n", an_n, e_an);
    chk("seg_n", seg_n, e_seg);
    chk("dp_n", dp_n, e_dp);
    chk("frame_tick", frame_tick, e_ft);
    chk("one_anode", ($countones(~an_n) <= 1), 1);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_tick", frame_tick, 1'b0);

    value   = 32'h1234ABCF;
    en_mask = 8'hFF;
    dp_mask = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    p = 0; m_val = '0; m_dp = '0;

    // Second frame, slot 0 offset 5 and slot 7 offset 5
    run_n(FRAME + 6);
    chk("slot0_an", an_n, 8'hFE);
    chk("slot0_seg", seg_n, 7'h0E);
    run_n(7 * SLOT);
    chk("slot7_an", an_n, 8'h7F);
    chk("slot7_seg", seg_n, 7'h79);

    // Change value in slot 3 of the third frame; old digits persist this frame
    while (p != 2 * FRAME + 3 * SLOT + 4) step();
    value = 32'h0;
    while (p != 3 * FRAME + 2 * SLOT + 9) step();
    chk("zero_an", an_n, 8'hFB);
    chk("zero_seg", seg_n, 7'h40);

    // Half the digits disabled, decimal point on digit 0
    value   = $urandom;
    en_mask = 8'h0F;
    dp_mask = 8'h01;
    run_n(2 * FRAME);

    // Random inputs changing at random points
    for (int k = 0; k < 10; k++) begin
      value   = $urandom;
      dp_mask = 8'($urandom_range(0, 255));
      en_mask = 8'($urandom_range(0, 255));
      run_n($urandom_range(20, 150));
    end

    // Asynchronous reset in the middle of slot 5
    en_mask = 8'hFF;
    while (p % FRAME != 5 * SLOT + 8) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", an_n, 8'hFF);
    chk("midrst_seg", seg_n, 7'h7F);
    chk("midrst_dp", dp_n, 1'b1);
    chk("midrst_ft", frame_tick, 1'b0);
    @(posedge clk);
    @(negedge clk);
    value   = $urandom;
    dp_mask = 8'hFF;
    rst = 1'b0;
    p = 0; m_val = '0; m_dp = '0;
    run_n(1);
    chk("restart_ft", frame_tick, 1'b1);
    run_n(SLOT + 5);
    chk("restart_an", an_n, 8'hFD);
    chk("restart_seg", seg_n, 7'h40);
    chk("restart_dp", dp_n, 1'b1);
    run_n(2 * FRAME + 20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
